// File: rtl/reg_trace_streamer_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | trace_pkg : shared record layout, FSM encoding and clog2 for trace IP    |
// | Revision  : 1.0                                                          |
// +-------------------------------------------------------------------------+
package trace_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SCAN  = 2'd1;
   localparam logic [1:0] ST_TRAIL = 2'd2;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // Record layout, LSB first: data, idx, id, trailer flag.
   function automatic int rec_off_data();
      return 0;
   endfunction

   function automatic int rec_off_idx(input int data_w);
      return data_w;
   endfunction

   function automatic int rec_off_id(input int data_w, input int idx_w);
      return data_w + idx_w;
   endfunction

   function automatic int rec_off_trl(input int data_w, input int idx_w, input int id_w);
      return data_w + idx_w + id_w;
   endfunction

   function automatic int rec_width(input int data_w, input int idx_w, input int id_w);
      return data_w + idx_w + id_w + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/reg_trace_streamer_fifo.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | sync_fifo_fwft : first-word-fall-through FIFO, push allowed when full    |
// | Revision       : 1.0                                                     |
// +-------------------------------------------------------------------------+
module sync_fifo_fwft
   import trace_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty
);

   localparam int AW = clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q;
   logic [AW:0]      rd_q;
   logic             w_do_pop;
   logic             w_do_push;

   assign empty     = (wr_q == rd_q);
   assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign w_do_pop  = pop & ~empty;
   // A full FIFO still takes a write when the head leaves in the same cycle.
   assign w_do_push = push & (~full | w_do_pop);
   assign dout      = empty ? '0 : mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (w_do_push) wr_q <= wr_q + 1'b1;
         if (w_do_pop)  rd_q <= rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) mem_q[wr_q[AW-1:0]] <= din;
   end

endmodule
`default_nettype wire

// File: rtl/reg_trace_streamer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | reg_trace_streamer : register snapshots -> (id, idx, value) record stream|
// | Revision           : 1.0                                                 |
// +-------------------------------------------------------------------------+
module reg_trace_streamer
   import trace_pkg::*;
#(
   parameter int NUM_REGS   = 32,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int SNAP_W     = 8,
   parameter int SKIP_ZERO  = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REGS*DATA_W-1:0]   regIn,
   input  logic                         snap,
   input  logic                         mode,
   output logic                         busy,
   output logic                         snap_drop,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_trailer,
   output logic [SNAP_W-1:0]            out_id,
   output logic [clog2(NUM_REGS)-1:0]   out_idx,
   output logic [DATA_W-1:0]            out_data
);

   localparam int IDX_W    = clog2(NUM_REGS);
   localparam int CNT_W    = clog2(NUM_REGS + 1);
   localparam int REC_W    = rec_width(DATA_W, IDX_W, SNAP_W);
   localparam int OFF_DATA = rec_off_data();
   localparam int OFF_IDX  = rec_off_idx(DATA_W);
   localparam int OFF_ID   = rec_off_id(DATA_W, IDX_W);
   localparam int OFF_TRL  = rec_off_trl(DATA_W, IDX_W, SNAP_W);
   localparam logic [IDX_W-1:0] FIRST_IDX = (SKIP_ZERO != 0) ? IDX_W'(1) : IDX_W'(0);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS - 1);

   generate
      if (CNT_W > DATA_W) begin : g_cnt_w_check
         $error("record count does not fit in DATA_W");
      end
   endgenerate

   logic [1:0]        state_q, state_d;
   logic              mode_q;
   logic [IDX_W-1:0]  idx_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [SNAP_W-1:0] id_q;
   logic              drop_q;
   logic [DATA_W-1:0] cap_q    [NUM_REGS];
   logic [DATA_W-1:0] shadow_q [NUM_REGS];

   logic              w_full, w_empty, w_pop, w_can_push, w_emit, w_push;
   logic [DATA_W-1:0] w_cur;
   logic [REC_W-1:0]  w_din, w_dout;

   assign w_pop      = out_ready & ~w_empty;
   assign w_can_push = ~w_full | w_pop;
   assign w_cur      = cap_q[idx_q];
   assign w_emit     = mode_q | (w_cur != shadow_q[idx_q]);

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (snap) state_d = ST_SCAN;
         ST_SCAN:  if (w_can_push && idx_q == LAST_IDX) state_d = ST_TRAIL;
         ST_TRAIL: if (w_can_push) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      w_push = 1'b0;
      w_din  = '0;
      case (state_q)
         ST_SCAN: begin
            if (w_can_push && w_emit) begin
               w_push                     = 1'b1;
               w_din[OFF_ID   +: SNAP_W]  = id_q;
               w_din[OFF_IDX  +: IDX_W]   = idx_q;
               w_din[OFF_DATA +: DATA_W]  = w_cur;
            end
         end
         ST_TRAIL: begin
            if (w_can_push) begin
               w_push                     = 1'b1;
               w_din[OFF_TRL]             = 1'b1;
               w_din[OFF_ID   +: SNAP_W]  = id_q;
               w_din[OFF_DATA +: DATA_W]  = DATA_W'(cnt_q);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mode_q <= 1'b0;
         idx_q  <= '0;
         cnt_q  <= '0;
         id_q   <= '0;
         drop_q <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
      end else begin
         if (state_q == ST_IDLE && snap) begin
            mode_q <= mode;
            idx_q  <= FIRST_IDX;
            cnt_q  <= '0;
         end
         if (state_q != ST_IDLE && snap) drop_q <= 1'b1;
         if (state_q == ST_SCAN && w_can_push) begin
            if (w_emit) begin
               shadow_q[idx_q] <= w_cur;
               cnt_q           <= cnt_q + CNT_W'(1);
            end
            if (idx_q != LAST_IDX) idx_q <= idx_q + IDX_W'(1);
         end
         if (state_q == ST_TRAIL && w_can_push) id_q <= id_q + SNAP_W'(1);
      end
   end

   // Register 0 sits in the most significant slice of regIn.
   always_ff @(posedge clk) begin
      if (state_q == ST_IDLE && snap) begin
         for (int i = 0; i < NUM_REGS; i++)
            cap_q[i] <= regIn[(NUM_REGS-1-i)*DATA_W +: DATA_W];
      end
   end

   sync_fifo_fwft #(
      .WIDTH (REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push),
      .din   (w_din),
      .full  (w_full),
      .pop   (w_pop),
      .dout  (w_dout),
      .empty (w_empty)
   );

   assign busy        = (state_q != ST_IDLE);
   assign snap_drop   = drop_q;
   assign out_valid   = ~w_empty;
   assign out_trailer = w_dout[OFF_TRL];
   assign out_id      = w_dout[OFF_ID   +: SNAP_W];
   assign out_idx     = w_dout[OFF_IDX  +: IDX_W];
   assign out_data    = w_dout[OFF_DATA +: DATA_W];

endmodule
`default_nettype wire
